// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: PC owner, imem req/gnt/rvalid master, decode valid/ready source
//
// Purpose:
//   Owns the program counter and fetches one 32-bit word at a time from
//   instruction memory. It presents each word with its PC to decode until
//   decode accepts it. Control-unit redirects (pc_src/branch_target) take
//   priority over everything else, and any fetch already in flight is dropped.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   Defined   : a redirect to a target with bits [1:0] != 0 parks the unit in
//               FAULT with fetch_fault=1 and the target on instr_pc, until reset.
//   Undefined : the low two target bits are cleared and fetch_fault is tied 0.
//
// Ports:
//   clk            in   1   core clock, rising edge
//   rstn           in   1   synchronous active-low reset
//   pc_src         in   1   redirect request
//   branch_target  in  32   redirect target PC
//   imem_req       out  1   fetch request (high only in FETCH)
//   imem_addr      out 32   fetch byte address (current PC)
//   imem_gnt       in   1   memory accepted the request
//   imem_rvalid    in   1   read data valid
//   imem_rdata     in  32   read data
//   instr_valid    out  1   instruction valid to decode
//   instr_ready    in   1   decode accepts instruction
//   instr          out 32   instruction (NOP_INSTR when not valid)
//   instr_pc       out 32   PC of the presented instruction
//   fetch_fault    out  1   sticky misaligned-redirect flag
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_discard, w_discard_nxt;
  logic        r_instr_valid, w_instr_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0] w_target;

  // Aligned redirect target; in the trap build a misaligned target never
  // reaches the normal paths because the FAULT override below wins.
  assign w_target = branch_target & 32'hFFFF_FFFC;

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_fault, w_fault_nxt;
  logic w_misalign;
  assign w_misalign  = pc_src && (branch_target[1:0] != 2'b00);
  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_discard     <= w_discard_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
`ifdef IFU_MISALIGN_TRAP_EN
      r_fault       <= w_fault_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_discard_nxt     = r_discard;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    w_fault_nxt       = r_fault;
`endif

    case (r_state)
      S_FETCH: begin
        if (pc_src) w_pc_nxt = w_target;
        if (imem_gnt) begin
          w_state_nxt = S_WAIT;
          // A request granted in the redirect cycle was for the old PC.
          w_discard_nxt = pc_src;
        end
      end
      S_WAIT: begin
        if (pc_src) begin
          w_pc_nxt      = w_target;
          w_discard_nxt = 1'b1;
        end
        if (imem_rvalid) begin
          if (r_discard || pc_src) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt       = S_HOLD;
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
          end
          w_discard_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        // A redirect overrides a simultaneous accept: no pc+4.
        if (pc_src || instr_ready) begin
          w_pc_nxt          = pc_src ? w_target : r_pc + 32'd4;
          w_state_nxt       = S_FETCH;
          w_instr_valid_nxt = 1'b0;
          w_instr_nxt       = NOP_INSTR;
        end
      end
`ifdef IFU_MISALIGN_TRAP_EN
      S_FAULT: begin
      end
`endif
      default: w_state_nxt = S_FETCH;
    endcase

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned redirect beats every state transition; FAULT is terminal.
    if (w_misalign && (r_state != S_FAULT)) begin
      w_state_nxt       = S_FAULT;
      w_fault_nxt       = 1'b1;
      w_pc_nxt          = branch_target;
      w_instr_pc_nxt    = branch_target;
      w_instr_valid_nxt = 1'b0;
      w_instr_nxt       = NOP_INSTR;
      w_discard_nxt     = 1'b0;
    end
`endif
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn, pc_src, imem_gnt, imem_rvalid, instr_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rstn(rstn), .pc_src(pc_src), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model, in transaction terms: an outstanding fetch (possibly
  // stale), a presented instruction, or neither (requesting).
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_out, m_stale, m_have, m_fault;

  task automatic model_step();
    logic [31:0] tg;
    tg = branch_target & ~32'h3;
    if (!rstn) begin
      m_pc = RST_PC; m_ipc = RST_PC; m_instr = NOP;
      m_out = 0; m_stale = 0; m_have = 0; m_fault = 0;
    end else if (m_fault) begin
    end
`ifdef IFU_MISALIGN_TRAP_EN
    else if (pc_src && branch_target[1:0] != 2'b00) begin
      m_fault = 1; m_have = 0; m_out = 0; m_stale = 0;
      m_instr = NOP; m_pc = branch_target; m_ipc = branch_target;
    end
`endif
    else if (m_have) begin
      if (pc_src) begin m_pc = tg; m_have = 0; m_instr = NOP; end
      else if (instr_ready) begin m_pc = m_pc + 4; m_have = 0; m_instr = NOP; end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out = 0;
        if (!m_stale && !pc_src) begin m_have = 1; m_instr = imem_rdata; m_ipc = m_pc; end
        m_stale = 0;
      end else if (pc_src) m_stale = 1;
      if (pc_src) m_pc = tg;
    end else begin
      if (imem_gnt) begin m_out = 1; m_stale = pc_src; end
      if (pc_src) m_pc = tg;
    end
  endtask

  function automatic logic [98:0] ex(logic rq, logic [31:0] ad, logic v,
                                     logic [31:0] in, logic [31:0] ip, logic f);
    return {rq, ad, v, in, ip, f};
  endfunction

  task automatic check(string nm, logic [98:0] exp);
    logic [98:0] got;
    got = {imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got req=%b addr=%h vld=%b instr=%h ipc=%h flt=%b exp req=%b addr=%h vld=%b instr=%h ipc=%h flt=%b",
                  nm, got[98], got[97:66], got[65], got[64:33], got[32:1], got[0],
                  exp[98], exp[97:66], exp[65], exp[64:33], exp[32:1], exp[0]);
  endtask

  task automatic tick(logic rs, logic src, logic [31:0] tg, logic g, logic rv,
                      logic [31:0] rd, logic rdy);
    rstn = rs; pc_src = src; branch_target = tg; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic rs, src; logic [31:0] tg; logic g, rv; logic [31:0] rd; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_instr, e_ipc;
  } vec_t;

  function automatic vec_t mk(logic rs, logic src, logic [31:0] tg, logic g, logic rv,
                              logic [31:0] rd, logic rdy, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_instr, logic [31:0] e_ipc);
    vec_t v;
    v.rs = rs; v.src = src; v.tg = tg; v.g = g; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  vec_t tbl[31];

  initial begin
    tbl[0]  = mk(0,0,0,0,0,0,0,              1,32'h0,  0,NOP,0);
    tbl[1]  = mk(1,0,0,1,0,0,0,              0,32'h0,  0,NOP,0);
    tbl[2]  = mk(1,0,0,0,1,32'h015A04B3,1,   0,32'h0,  1,32'h015A04B3,0);
    tbl[3]  = mk(1,0,0,0,0,0,1,              1,32'h4,  0,NOP,0);
    tbl[4]  = mk(1,0,0,1,0,0,0,              0,32'h4,  0,NOP,0);
    tbl[5]  = mk(1,0,0,0,1,32'h00100093,0,   0,32'h4,  1,32'h00100093,32'h4);
    tbl[6]  = mk(1,0,0,0,0,0,0,              0,32'h4,  1,32'h00100093,32'h4);
    tbl[7]  = mk(1,0,0,0,0,0,0,              0,32'h4,  1,32'h00100093,32'h4);
    tbl[8]  = mk(1,0,0,0,1,32'hFFFFFFFF,0,   0,32'h4,  1,32'h00100093,32'h4);
    tbl[9]  = mk(1,0,0,0,0,0,0,              0,32'h4,  1,32'h00100093,32'h4);
    tbl[10] = mk(1,0,0,0,0,0,0,              0,32'h4,  1,32'h00100093,32'h4);
    tbl[11] = mk(1,0,0,0,0,0,1,              1,32'h8,  0,NOP,32'h4);
    tbl[12] = mk(1,0,0,1,0,0,0,              0,32'h8,  0,NOP,32'h4);
    tbl[13] = mk(1,0,0,0,1,32'h00208113,0,   0,32'h8,  1,32'h00208113,32'h8);
    tbl[14] = mk(1,1,32'h40,0,0,0,1,         1,32'h40, 0,NOP,32'h8);
    tbl[15] = mk(1,0,0,1,0,0,0,              0,32'h40, 0,NOP,32'h8);
    tbl[16] = mk(1,1,32'h100,0,1,32'h00812703,0, 1,32'h100,0,NOP,32'h8);
    tbl[17] = mk(1,0,0,1,0,0,0,              0,32'h100,0,NOP,32'h8);
    tbl[18] = mk(1,0,0,0,1,32'h11111111,0,   0,32'h100,1,32'h11111111,32'h100);
    tbl[19] = mk(1,0,0,0,0,0,1,              1,32'h104,0,NOP,32'h100);
    tbl[20] = mk(1,1,32'h200,1,0,0,0,        0,32'h200,0,NOP,32'h100);
    tbl[21] = mk(1,0,0,0,1,32'hDEADBEEF,0,   1,32'h200,0,NOP,32'h100);
    tbl[22] = mk(1,0,0,1,0,0,0,              0,32'h200,0,NOP,32'h100);
    tbl[23] = mk(1,0,0,0,1,32'hCAFEF00D,0,   0,32'h200,1,32'hCAFEF00D,32'h200);
    tbl[24] = mk(1,0,0,0,0,0,1,              1,32'h204,0,NOP,32'h200);
    tbl[25] = mk(1,0,0,0,1,32'h12345678,0,   1,32'h204,0,NOP,32'h200);
    tbl[26] = mk(1,1,32'h300,0,0,0,0,        1,32'h300,0,NOP,32'h200);
    tbl[27] = mk(1,1,32'h380,0,0,0,0,        1,32'h380,0,NOP,32'h200);
    tbl[28] = mk(1,0,0,1,0,0,0,              0,32'h380,0,NOP,32'h200);
    tbl[29] = mk(0,0,0,0,0,0,0,              1,32'h0,  0,NOP,32'h0);
    tbl[30] = mk(1,0,0,0,1,32'hAAAA5555,0,   1,32'h0,  0,NOP,32'h0);

    for (int i = 0; i < 31; i++) begin
      tick(tbl[i].rs, tbl[i].src, tbl[i].tg, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      check($sformatf("vec%0d", i),
            ex(tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_instr, tbl[i].e_ipc, 1'b0));
    end

    // PC wrap at the top of the address space.
    tick(1,1,32'hFFFFFFFC,0,0,0,0);
    check("wrap_redir", ex(1,32'hFFFFFFFC,0,NOP,32'h0,0));
    tick(1,0,0,1,0,0,0);
    tick(1,0,0,0,1,32'h13579BDF,0);
    check("wrap_hold", ex(0,32'hFFFFFFFC,1,32'h13579BDF,32'hFFFFFFFC,0));
    tick(1,0,0,0,0,0,1);
    check("wrap_next", ex(1,32'h0,0,NOP,32'hFFFFFFFC,0));

    // Misaligned redirect target.
    tick(1,1,32'h102,0,0,0,0);
`ifdef IFU_MISALIGN_TRAP_EN
    check("mis_fault", ex(0,32'h102,0,NOP,32'h102,1));
    for (int i = 0; i < 3; i++) begin
      tick(1,(i == 1),32'h200,1,1,32'h0BADF00D,1);
      check($sformatf("mis_sticky%0d", i), ex(0,32'h102,0,NOP,32'h102,1));
    end
`else
    check("mis_align", ex(1,32'h100,0,NOP,32'hFFFFFFFC,0));
    tick(1,0,0,1,0,0,0);
    check("mis_wait", ex(0,32'h100,0,NOP,32'hFFFFFFFC,0));
`endif
    tick(0,0,0,0,0,0,0);
    check("mis_reset", ex(1,RST_PC,0,NOP,RST_PC,0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      logic rv;
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      rv = m_out ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      tick((i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 5) == 0), tg, logic'($urandom_range(0, 1)), rv,
           $urandom, logic'($urandom_range(0, 1)));
      check($sformatf("rand%0d", i),
            ex(!m_fault && !m_out && !m_have, m_pc, m_have, m_instr, m_ipc, m_fault));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
